// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: capture controller for a PDM microphone front end.
// Sequences mic enable, discards warm-up samples, captures a block (or runs
// continuously) into a show-ahead FIFO and flags dropped samples.
// Optional peak-magnitude tracking is enabled by defining the macro
// PDM_CAPTURE_CTRL_PEAK_DETECT_EN; without it peak is tied to zero.
module pdm_capture_ctrl #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 64,
    parameter int unsigned WARMUP_SAMPLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          flush,
    input  logic [15:0]                   block_len,
    input  logic                          pcm_valid,
    input  logic [DATA_WIDTH-1:0]         pcm_in,
    output logic                          mic_en,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DATA_WIDTH-1:0]         peak
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned WCW = $clog2(WARMUP_SAMPLES + 1) + 1;

    localparam logic [LW-1:0]  LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [WCW-1:0] WARM_LAST  = WCW'(WARMUP_SAMPLES);

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StCapture,
        StDone
    } state_t;

    state_t state;

    logic [15:0]     blk_len_q;
    logic [15:0]     cap_cnt_q;
    logic [15:0]     cap_next;
    logic [WCW-1:0]  warm_cnt_q;
    logic [WCW-1:0]  warm_next;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         count;

    logic full;
    logic pop;
    logic cap_sample;
    logic push;

    assign cap_next  = cap_cnt_q + 16'd1;
    assign warm_next = warm_cnt_q + WCW'(1);

    assign full       = (count == LEVEL_FULL);
    assign rd_valid   = (count != '0);
    assign pop        = rd_valid && rd_ready;
    // A sample that coincides with abort is never written.
    assign cap_sample = (state == StCapture) && pcm_valid && !abort;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push       = cap_sample && (!full || pop);

    assign fifo_level = count;
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;

    // Capture sequencing FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            mic_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            blk_len_q  <= '0;
            cap_cnt_q  <= '0;
            warm_cnt_q <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        blk_len_q  <= block_len;
                        overflow   <= 1'b0;
                        cap_cnt_q  <= '0;
                        warm_cnt_q <= '0;
                        busy       <= 1'b1;
                        mic_en     <= 1'b1;
                        state      <= (WARMUP_SAMPLES == 0) ? StCapture : StWarmup;
                    end
                end
                StWarmup: begin
                    if (abort) begin
                        state  <= StIdle;
                        mic_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (pcm_valid) begin
                        warm_cnt_q <= warm_next;
                        if (warm_next == WARM_LAST) begin
                            state <= StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (abort) begin
                        state  <= StIdle;
                        mic_en <= 1'b0;
                        busy   <= 1'b0;
                    end else if (pcm_valid) begin
                        cap_cnt_q <= cap_next;
                        if (full && !pop) begin
                            overflow <= 1'b1;
                        end
                        // block_len of zero means run until abort.
                        if ((blk_len_q != 16'd0) && (cap_next == blk_len_q)) begin
                            state  <= StDone;
                            done   <= 1'b1;
                            mic_en <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= StIdle;
                    mic_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= pcm_in;
        end
    end

`ifdef PDM_CAPTURE_CTRL_PEAK_DETECT_EN
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] peak_q;

    // Magnitude of the incoming sample; the most negative code saturates.
    always_comb begin
        mag = pcm_in;
        if (pcm_in[DATA_WIDTH-1]) begin
            if (pcm_in == MIN_NEG) begin
                mag = MAX_POS;
            end else begin
                mag = -pcm_in;
            end
        end
    end

    // Running maximum of written sample magnitudes, cleared on a new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if ((state == StIdle) && start) begin
            peak_q <= '0;
        end else if (push && !flush && (mag > peak_q)) begin
            peak_q <= mag;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl (DEPTH 4, 4 warm-up samples).
// A queue holds the samples expected out of the FIFO, in order.
module tb_pdm_capture_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] block_len = '0;
    logic        pcm_valid = 1'b0;
    logic [15:0] pcm_in = '0;
    logic        rd_ready = 1'b0;
    logic        mic_en;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  fifo_level;
    logic [15:0] peak;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int pop_cnt = 0;
    logic [15:0] sb[$];
    bit m_cap = 1'b0;
    bit m_ovf = 1'b0;
    logic [15:0] exp_peak;

    pdm_capture_ctrl #(
        .DATA_WIDTH    (16),
        .FIFO_DEPTH    (DEPTH),
        .WARMUP_SAMPLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .flush     (flush),
        .block_len (block_len),
        .pcm_valid (pcm_valid),
        .pcm_in    (pcm_in),
        .mic_en    (mic_en),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .fifo_level(fifo_level),
        .peak      (peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score pops/pushes against the model, then advance.
    task automatic cyc();
        bit m_pop;
        bit m_full;
        m_full = (sb.size() == DEPTH);
        m_pop  = (sb.size() != 0) && rd_ready && !flush;
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, sb.size() != 0});
        if (m_pop) begin
            chk("rd_data", {16'd0, rd_data}, {16'd0, sb[0]});
            pop_cnt++;
            void'(sb.pop_front());
        end
        if (done) done_cnt++;
        if (m_cap && pcm_valid && !abort && !flush) begin
            if (!m_full || m_pop) sb.push_back(pcm_in);
            else m_ovf = 1'b1;
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [15:0] len);
        block_len = len;
        start = 1'b1;
        m_cap = 1'b0;
        cyc();
        start = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic warmup();
        m_cap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pcm_valid = 1'b1;
            pcm_in = 16'h1000 + 16'(i);
            cyc();
        end
        m_cap = 1'b1;
    endtask

    initial begin
`ifdef PDM_CAPTURE_CTRL_PEAK_DETECT_EN
        exp_peak = 16'h7FFF;
`else
        exp_peak = 16'h0000;
`endif
        // Reset values
        #2;
        chk("rst_mic_en", {31'd0, mic_en}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_rd_data", {16'd0, rd_data}, 0);
        chk("rst_peak", {16'd0, peak}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic capture: 12 samples, first 4 discarded, block of 8
        rd_ready = 1'b1;
        pop_cnt = 0;
        start_run(16'd8);
        chk("warm_mic_en", {31'd0, mic_en}, 1);
        chk("warm_busy", {31'd0, busy}, 1);
        for (int i = 1; i <= 12; i++) begin
            pcm_valid = 1'b1;
            pcm_in = 16'(i);
            m_cap = (i > 4);
            if (i == 5) chk("cap_mic_en", {31'd0, mic_en}, 1);
            cyc();
        end
        pcm_valid = 1'b0;
        m_cap = 1'b0;
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_mic_en", {31'd0, mic_en}, 0);
        chk("done_busy", {31'd0, busy}, 1);
        cyc();
        chk("done_low", {31'd0, done}, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 3; i++) cyc();
        chk("basic_reads", pop_cnt, 8);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_mic_off", {31'd0, mic_en}, 0);

        // Overflow: block of 6, consumer stalled
        rd_ready = 1'b0;
        start_run(16'd6);
        warmup();
        for (int i = 21; i <= 26; i++) begin
            pcm_valid = 1'b1;
            pcm_in = 16'(i);
            // start outside IDLE must be ignored
            if (i == 21) begin
                start = 1'b1;
                block_len = 16'd2;
            end
            cyc();
            start = 1'b0;
        end
        pcm_valid = 1'b0;
        m_cap = 1'b0;
        chk("ovf_done", {31'd0, done}, 1);
        chk("ovf_level", {29'd0, fifo_level}, sb.size());
        chk("ovf_flag", {31'd0, overflow}, {31'd0, m_ovf});
        cyc();
        chk("ovf_done_cnt", done_cnt, 2);

        // Full FIFO: push and pop in the same cycle, then abort
        start_run(16'd0);
        chk("start_clr_ovf", {31'd0, overflow}, 0);
        warmup();
        rd_ready = 1'b1;
        pcm_valid = 1'b1;
        pcm_in = 16'd27;
        cyc();
        chk("pp_level", {29'd0, fifo_level}, 4);
        chk("pp_overflow", {31'd0, overflow}, 0);
        rd_ready = 1'b0;
        abort = 1'b1;
        pcm_in = 16'd99;
        cyc();
        abort = 1'b0;
        pcm_valid = 1'b0;
        m_cap = 1'b0;
        chk("abort1_busy", {31'd0, busy}, 0);
        chk("abort1_level", {29'd0, fifo_level}, 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        rd_ready = 1'b0;
        chk("drain_level", {29'd0, fifo_level}, 0);

        // Continuous capture of 3 samples, abort, peak
        start_run(16'd0);
        warmup();
        pcm_valid = 1'b1;
        pcm_in = 16'd100;
        cyc();
        pcm_in = 16'hFED4;
        cyc();
        pcm_in = 16'h8000;
        cyc();
        chk("abort_pre_level", {29'd0, fifo_level}, 3);
        abort = 1'b1;
        pcm_in = 16'd7;
        cyc();
        abort = 1'b0;
        pcm_valid = 1'b0;
        m_cap = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_mic_en", {31'd0, mic_en}, 0);
        chk("abort_level", {29'd0, fifo_level}, 3);
        chk("abort_no_done", done_cnt, 2);
        chk("peak", {16'd0, peak}, {16'd0, exp_peak});

        // Flush empties the FIFO
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_level", {29'd0, fifo_level}, 0);
        chk("flush_rd_valid", {31'd0, rd_valid}, 0);
        chk("flush_rd_data", {16'd0, rd_data}, 0);

        // Asynchronous reset in the middle of a capture
        start_run(16'd0);
        warmup();
        pcm_valid = 1'b1;
        pcm_in = 16'h8000;
        cyc();
        pcm_in = 16'h0066;
        cyc();
        pcm_valid = 1'b0;
        m_cap = 1'b0;
        chk("ar_pre_level", {29'd0, fifo_level}, 2);
        chk("ar_pre_mic_en", {31'd0, mic_en}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mic_en", {31'd0, mic_en}, 0);
        chk("ar_busy", {31'd0, busy}, 0);
        chk("ar_done", {31'd0, done}, 0);
        chk("ar_overflow", {31'd0, overflow}, 0);
        chk("ar_rd_valid", {31'd0, rd_valid}, 0);
        chk("ar_level", {29'd0, fifo_level}, 0);
        chk("ar_rd_data", {16'd0, rd_data}, 0);
        chk("ar_peak", {16'd0, peak}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_busy", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
